sim_input_stream_widen: RTL

SIM_INPUT_STREAM_WIDEN -- requirements
Module: sim_input_stream_widen

---
 rtl/sim_input_stream_widen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sim_input_stream_widen.sv
// Packs narrow input words into wide output beats (little-endian lanes) and
// queues completed beats in a first-word-fall-through FIFO.
module sim_input_stream_widen #(
  parameter int IN_BITS  = 64,
  parameter int OUT_BITS = 256,
  parameter int DEPTH    = 4,
  localparam int R       = OUT_BITS / IN_BITS,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_bits,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_bits,
  output logic [R-1:0]        out_keep,
  output logic                out_last,
  output logic [CNT_W-1:0]    count
);

  localparam int LANE_W = (R > 1) ? $clog2(R) : 1;
  localparam int PTR_W  = $clog2(DEPTH);

  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [OUT_BITS-1:0] acc_bits_q, acc_bits_d;
  logic [R-1:0]        acc_keep_q, acc_keep_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [OUT_BITS-1:0] mem_bits_q [DEPTH];
  logic [OUT_BITS-1:0] mem_bits_d [DEPTH];
  logic [R-1:0]        mem_keep_q [DEPTH];
  logic [R-1:0]        mem_keep_d [DEPTH];
  logic                mem_last_q [DEPTH];
  logic                mem_last_d [DEPTH];

  logic                in_fire;
  logic                out_fire;
  logic                beat_done;
  logic [OUT_BITS-1:0] beat_bits;
  logic [R-1:0]        beat_keep;

  // No full-bypass: a pop in the same cycle does not open the input.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    beat_bits = acc_bits_q;
    beat_keep = acc_keep_q;
    for (int k = 0; k < R; k++) begin
      if (in_fire && (lane_q == LANE_W'(k))) begin
        beat_bits[k*IN_BITS +: IN_BITS] = in_bits;
        beat_keep[k]                    = 1'b1;
      end
    end
    beat_done = in_fire && (in_last || (lane_q == LANE_W'(R - 1)));

    lane_d     = lane_q;
    acc_bits_d = acc_bits_q;
    acc_keep_d = acc_keep_q;
    if (beat_done) begin
      lane_d     = '0;
      acc_bits_d = '0;
      acc_keep_d = '0;
    end else if (in_fire) begin
      lane_d     = lane_q + LANE_W'(1);
      acc_bits_d = beat_bits;
      acc_keep_d = beat_keep;
    end
  end

  // The beat is written straight from the assembler so it lands in the FIFO
  // on the same edge that accepts its final word.
  always_comb begin
    mem_bits_d = mem_bits_q;
    mem_keep_d = mem_keep_q;
    mem_last_d = mem_last_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (beat_done) begin
      mem_bits_d[wr_ptr_q] = beat_bits;
      mem_keep_d[wr_ptr_q] = beat_keep;
      mem_last_d[wr_ptr_q] = in_last;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (out_fire) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({beat_done, out_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    out_bits = '0;
    out_keep = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_bits = mem_bits_q[rd_ptr_q];
      out_keep = mem_keep_q[rd_ptr_q];
      out_last = mem_last_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_q     <= '0;
      acc_bits_q <= '0;
      acc_keep_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      lane_q     <= lane_d;
      acc_bits_q <= acc_bits_d;
      acc_keep_q <= acc_keep_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clock) begin
    mem_bits_q <= mem_bits_d;
    mem_keep_q <= mem_keep_d;
    mem_last_q <= mem_last_d;
  end

endmodule
